mux2_sched: RTL and testbench

- Round-robin scheduler for the shared 12-bit 2:1 peripheral sample mux.
- Two requesters (channel 0 = in0 side, channel 1 = in1 side) ask for a sample.
- The block drives the mux select, waits a programmable settle time after every select change, and captures the mux output.
- It presents the sample downstream with a valid/ready handshake and acknowledges the requester that was served.

---
 rtl/mux2_sched.sv | 147 ++++++++++++++
 tb/tb_mux2_sched.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux2_sched.sv
// Round-robin scheduler for a shared 2:1 sample mux: drives the select, waits for
// the mux to settle, captures the sample and hands it downstream with valid/ready.
module mux2_sched #(
    parameter int WIDTH         = 12,
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    output logic             ack0,
    output logic             ack1,
    output logic             s,
    input  logic [WIDTH-1:0] mux_out,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ch,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        CAPTURE,
        HOLD,
        ACK
    } state_t;

    localparam int              SC_W        = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam bit              HAS_SETTLE  = (SETTLE_CYCLES > 0);

    state_t          state;
    logic            grant;
    logic            last_grant;
    logic [SC_W-1:0] settle_cnt;

    logic pick_valid;
    logic pick;
    logic pick_s;
    logic granted_req;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        pick_valid  = req0 | req1;
        pick        = 1'b0;
        if (req0 && req1)
            pick = ~last_grant;
        else if (req1)
            pick = 1'b1;
        pick_s      = ~pick;
        granted_req = grant ? req1 : req0;
    end

    // NOTE: all state and registered outputs use non-blocking assignments only, so every
    // branch reads the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            s          <= 1'b1;
            last_grant <= 1'b1;
            grant      <= 1'b0;
            settle_cnt <= '0;
            out_data   <= '0;
            out_ch     <= 1'b0;
            out_valid  <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            busy       <= 1'b0;
            cnt0       <= '0;
            cnt1       <= '0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant      <= pick;
                        last_grant <= pick;
                        s          <= pick_s;
                        busy       <= 1'b1;
                        // Only a real select change needs the mux to settle.
                        if (HAS_SETTLE && (pick_s != s)) begin
                            state      <= SETTLE;
                            settle_cnt <= '0;
                        end else begin
                            state <= CAPTURE;
                        end
                    end
                end

                SETTLE: begin
                    if (!granted_req) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        settle_cnt <= settle_cnt + SC_W'(1);
                        if (settle_cnt == SETTLE_LAST)
                            state <= CAPTURE;
                    end
                end

                CAPTURE: begin
                    if (!granted_req) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        out_data  <= mux_out;
                        out_ch    <= grant;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end

                HOLD: begin
                    // A dropped request here is ignored: the sample is already committed.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ACK;
                        if (grant) begin
                            cnt1 <= cnt1 + CNT_W'(1);
                            ack1 <= 1'b1;
                        end else begin
                            cnt0 <= cnt0 + CNT_W'(1);
                            ack0 <= 1'b1;
                        end
                    end
                end

                ACK: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux2_sched.sv
// Directed bench for mux2_sched: latency, settle, round robin, back-pressure,
// withdrawal, async reset and counter wrap, against hand-computed values.
module tb_mux2_sched;

    localparam int WIDTH = 12;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0, req1;
    logic             ack0, ack1;
    logic             s;
    logic [WIDTH-1:0] mux_out;
    logic [WIDTH-1:0] out_data;
    logic             out_ch;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic [CNT_W-1:0] cnt0, cnt1;

    int total = 0;
    int bad   = 0;

    mux2_sched #(
        .WIDTH(WIDTH),
        .SETTLE_CYCLES(2),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req0(req0),
        .req1(req1),
        .ack0(ack0),
        .ack1(ack1),
        .s(s),
        .mux_out(mux_out),
        .out_data(out_data),
        .out_ch(out_ch),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy(busy),
        .cnt0(cnt0),
        .cnt1(cnt1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Complete one channel-0 transfer with a bounded wait for its ack.
    task automatic xfer0(input logic [WIDTH-1:0] data);
        bit found;
        found     = 1'b0;
        req0      = 1'b1;
        mux_out   = data;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && !found; c++) begin
            tick();
            if (ack0) found = 1'b1;
        end
        check("xfer0_done", 32'(found), 1);
        req0 = 1'b0;
        tick();
    endtask

    initial begin
        bit   found;
        logic exp_ch [4];

        rst       = 1'b1;
        req0      = 1'b0;
        req1      = 1'b0;
        mux_out   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_s", 32'(s), 1);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_data", 32'(out_data), 0);
        check("rst_cnt0", 32'(cnt0), 0);
        check("rst_cnt1", 32'(cnt1), 0);
        rst = 1'b0;
        tick();

        // Channel 0, select unchanged: capture right away.
        req0 = 1'b1; mux_out = 'hABC; out_ready = 1'b1;
        tick();
        check("s1_busy", 32'(busy), 1);
        check("s1_s", 32'(s), 1);
        check("s1_valid_early", 32'(out_valid), 0);
        tick();
        check("s1_valid", 32'(out_valid), 1);
        check("s1_data", 32'(out_data), 'hABC);
        check("s1_ch", 32'(out_ch), 0);
        tick();
        check("s1_ack0", 32'(ack0), 1);
        check("s1_ack1", 32'(ack1), 0);
        check("s1_valid_clr", 32'(out_valid), 0);
        check("s1_cnt0", 32'(cnt0), 1);
        req0 = 1'b0;
        tick();
        check("s1_ack0_pulse", 32'(ack0), 0);
        check("s1_idle", 32'(busy), 0);

        // Channel 1: select flips, two settle cycles before capture.
        req1 = 1'b1; mux_out = 'h123;
        tick();
        check("s2_s", 32'(s), 0);
        check("s2_busy", 32'(busy), 1);
        tick();
        check("s2_settle1", 32'(out_valid), 0);
        tick();
        check("s2_settle2", 32'(out_valid), 0);
        tick();
        check("s2_valid", 32'(out_valid), 1);
        check("s2_data", 32'(out_data), 'h123);
        check("s2_ch", 32'(out_ch), 1);
        tick();
        check("s2_ack1", 32'(ack1), 1);
        check("s2_ack0", 32'(ack0), 0);
        check("s2_cnt1", 32'(cnt1), 1);
        req1 = 1'b0;
        tick();

        // Back-pressure in HOLD for 10 cycles.
        req0 = 1'b1; mux_out = 'h5A5; out_ready = 1'b0;
        repeat (4) tick();
        check("s4_valid", 32'(out_valid), 1);
        check("s4_data", 32'(out_data), 'h5A5);
        check("s4_ch", 32'(out_ch), 0);
        mux_out = 'hFFF;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("s4_hold_valid", 32'(out_valid), 1);
            check("s4_hold_data", 32'(out_data), 'h5A5);
            check("s4_hold_ack", 32'(ack0), 0);
        end
        out_ready = 1'b1;
        tick();
        check("s4_ack0", 32'(ack0), 1);
        check("s4_valid_clr", 32'(out_valid), 0);
        check("s4_cnt0", 32'(cnt0), 2);
        req0 = 1'b0;
        tick();

        // Both requesting: last grant was 0, so order is 1,0,1,0.
        exp_ch[0] = 1'b1; exp_ch[1] = 1'b0; exp_ch[2] = 1'b1; exp_ch[3] = 1'b0;
        req0 = 1'b1; req1 = 1'b1; mux_out = 'h3C3;
        for (int k = 0; k < 4; k++) begin
            found = 1'b0;
            for (int c = 0; c < 20 && !found; c++) begin
                tick();
                if (ack0 || ack1) found = 1'b1;
            end
            check("s3_ack_seen", 32'(found), 1);
            check("s3_ack1", 32'(ack1), 32'(exp_ch[k]));
            check("s3_ack0", 32'(ack0), 32'(!exp_ch[k]));
            check("s3_s", 32'(s), 32'(!exp_ch[k]));
            if (exp_ch[k]) req1 = 1'b0; else req0 = 1'b0;
            tick();
            req0 = 1'b1; req1 = 1'b1;
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();
        check("s3_cnt0", 32'(cnt0), 0);
        check("s3_cnt1", 32'(cnt1), 3);

        // Withdrawal during SETTLE.
        req1 = 1'b1;
        tick();
        check("s5_s_new", 32'(s), 0);
        check("s5_busy", 32'(busy), 1);
        req1 = 1'b0;
        tick();
        check("s5_busy_low", 32'(busy), 0);
        check("s5_s_kept", 32'(s), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("s5_no_valid", 32'(out_valid), 0);
            check("s5_no_ack", 32'(ack1), 0);
        end
        check("s5_cnt1", 32'(cnt1), 3);

        // Withdrawal in the CAPTURE cycle (select already 0, no settle).
        req1 = 1'b1; mux_out = 'h0F0;
        tick();
        check("s5c_busy", 32'(busy), 1);
        req1 = 1'b0;
        tick();
        check("s5c_busy_low", 32'(busy), 0);
        check("s5c_no_valid", 32'(out_valid), 0);
        tick();
        check("s5c_no_ack", 32'(ack1), 0);
        check("s5c_cnt1", 32'(cnt1), 3);

        // Async reset while holding a valid sample.
        req0 = 1'b1; mux_out = 'h777; out_ready = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            tick();
            if (out_valid) found = 1'b1;
        end
        check("s6_valid_seen", 32'(found), 1);
        #2 rst = 1'b1;
        #1;
        check("s6_valid", 32'(out_valid), 0);
        check("s6_ack0", 32'(ack0), 0);
        check("s6_ack1", 32'(ack1), 0);
        check("s6_busy", 32'(busy), 0);
        check("s6_cnt0", 32'(cnt0), 0);
        check("s6_cnt1", 32'(cnt1), 3'd0);
        check("s6_s", 32'(s), 1);
        req0 = 1'b0;
        #3 rst = 1'b0;
        tick();

        // Five channel-0 transfers with a 2-bit counter: 5 mod 4 = 1.
        for (int i = 0; i < 5; i++)
            xfer0(WIDTH'(i + 1));
        check("wrap_cnt0", 32'(cnt0), 1);
        check("wrap_cnt1", 32'(cnt1), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
